// File: rtl/echo_responder.sv
// Ultrasonic echo responder: qualifies a trigger pulse, waits a burst interval, then emits an echo
// whose width encodes distance_cm. Optional counter enabled by macro ECHO_RESPONDER_COUNT_EN.
module echo_responder #(
    parameter int unsigned CLK_PER_CM  = 2941,
    parameter int unsigned TRIG_MIN    = 500,
    parameter int unsigned BURST_CYC   = 10000,
    parameter int unsigned HOLDOFF_CYC = 50000,
    parameter int unsigned MAX_CM      = 400
) (
    input  logic        clk_50M,
    input  logic        reset_n,
    input  logic        trig_in,
    input  logic [8:0]  distance_cm,
    output logic        echo_tx,
    output logic        busy,
    output logic        trig_err,
    output logic [2:0]  state,
    output logic [15:0] echo_count
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTrig    = 3'd1,
        StBurst   = 3'd2,
        StEcho    = 3'd3,
        StHoldoff = 3'd4
    } state_e;

    localparam logic [21:0] TrigMin   = 22'(TRIG_MIN);
    localparam logic [21:0] BurstLast = 22'(BURST_CYC - 1);
    localparam logic [21:0] PerCmLast = 22'(CLK_PER_CM - 1);
    localparam logic [21:0] HoldLast  = 22'(HOLDOFF_CYC - 1);
    localparam logic [8:0]  MaxCm     = 9'(MAX_CM);

    state_e      state_q, state_d;
    logic [21:0] cnt_q, cnt_d;
    logic [8:0]  cm_q, cm_d;
    logic [8:0]  dist_q, dist_d;
    logic        trig_prev_q;
    logic        echo_q, echo_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (trig_in && !trig_prev_q) begin
                    state_d = StTrig;
                    cnt_d   = 22'd1;
                end
            end
            StTrig: begin
                if (trig_in) begin
                    if (cnt_q < TrigMin) cnt_d = cnt_q + 22'd1;
                end else if (cnt_q >= TrigMin) begin
                    dist_d  = (distance_cm > MaxCm) ? MaxCm : distance_cm;
                    cnt_d   = '0;
                    state_d = StBurst;
                end else begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StBurst: begin
                if (cnt_q == BurstLast) begin
                    cnt_d   = '0;
                    cm_d    = '0;
                    state_d = (dist_q == 9'd0) ? StHoldoff : StEcho;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            StEcho: begin
                // Inner counter spans one cm of echo, outer counter counts cm.
                if (cnt_q == PerCmLast) begin
                    cnt_d = '0;
                    if (cm_q == dist_q - 9'd1) begin
                        cm_d    = '0;
                        state_d = StHoldoff;
                    end else begin
                        cm_d = cm_q + 9'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            StHoldoff: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                cm_d    = '0;
            end
        endcase
        echo_d = (state_d == StEcho);
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cm_q        <= '0;
            dist_q      <= '0;
            trig_prev_q <= 1'b1;
            echo_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cm_q        <= cm_d;
            dist_q      <= dist_d;
            trig_prev_q <= trig_in;
            echo_q      <= echo_d;
            err_q       <= err_d;
        end
    end

`ifdef ECHO_RESPONDER_COUNT_EN
    logic [15:0] echo_count_q;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            echo_count_q <= '0;
        end else if (state_q == StEcho && state_d == StHoldoff && echo_count_q != 16'hFFFF) begin
            echo_count_q <= echo_count_q + 16'd1;
        end
    end

    assign echo_count = echo_count_q;
`else
    assign echo_count = 16'd0;
`endif

    assign state    = state_q;
    assign echo_tx  = echo_q;
    assign trig_err = err_q;
    assign busy     = (state_q != StIdle) && (state_q != StTrig);

endmodule

// File: tb/tb_echo_responder.sv
// Directed self-checking bench for echo_responder, run with scaled-down timing parameters.
module tb_echo_responder;

    localparam int unsigned CPC  = 7;
    localparam int unsigned TMIN = 5;
    localparam int unsigned BCYC = 20;
    localparam int unsigned HCYC = 30;
    localparam int unsigned MCM  = 40;
    localparam int          WIN  = 400;

    logic        clk_50M = 1'b0;
    logic        reset_n;
    logic        trig_in;
    logic [8:0]  distance_cm;
    logic        echo_tx;
    logic        busy;
    logic        trig_err;
    logic [2:0]  state;
    logic [15:0] echo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;
    int lat, width, rises, busyc, errc, errfirst, bad_states;

    echo_responder #(
        .CLK_PER_CM (CPC),
        .TRIG_MIN   (TMIN),
        .BURST_CYC  (BCYC),
        .HOLDOFF_CYC(HCYC),
        .MAX_CM     (MCM)
    ) dut (
        .clk_50M    (clk_50M),
        .reset_n    (reset_n),
        .trig_in    (trig_in),
        .distance_cm(distance_cm),
        .echo_tx    (echo_tx),
        .busy       (busy),
        .trig_err   (trig_err),
        .state      (state),
        .echo_count (echo_count)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exactly n rising-edge samples of trig_in=1, then low from the next edge on.
    task automatic pulse(input int n);
        trig_in = 1'b1;
        repeat (n) tick();
        trig_in = 1'b0;
    endtask

    // Cycle i is sampled just after the i-th edge following the trigger fall.
    task automatic observe(input int ra, input int rl, output int o_lat, output int o_width,
                           output int o_rises, output int o_busy, output int o_err,
                           output int o_errfirst);
        logic prev_echo;
        prev_echo = 1'b0;
        o_lat = 0; o_width = 0; o_rises = 0; o_busy = 0; o_err = 0; o_errfirst = 0;
        for (int i = 1; i <= WIN; i++) begin
            tick();
            if (echo_tx) begin
                o_width++;
                if (o_lat == 0) o_lat = i;
                if (!prev_echo) o_rises++;
            end
            prev_echo = echo_tx;
            if (busy) o_busy++;
            if (trig_err) begin
                o_err++;
                if (o_errfirst == 0) o_errfirst = i;
            end
            if (i == 1) distance_cm = 9'd77;
            trig_in = (i >= ra && i < ra + rl);
        end
        trig_in = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        trig_in     = 1'b1;
        distance_cm = 9'd0;
        repeat (3) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_echo", 32'(echo_tx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(trig_err), 0);
        chk("rst_count", 32'(echo_count), 0);

        // trig_in already high at release must not start a measurement
        reset_n = 1'b1;
        bad_states = 0;
        repeat (10) begin
            tick();
            if (state != 3'd0) bad_states++;
        end
        chk("no_false_edge", 32'(bad_states), 0);
        trig_in = 1'b0;
        tick();

        // Valid trigger, distance 10
        distance_cm = 9'd10;
        pulse(TMIN);
        observe(0, 0, lat, width, rises, busyc, errc, errfirst);
        chk("d10_latency", 32'(lat), BCYC + 1);
        chk("d10_width", 32'(width), 10 * CPC);
        chk("d10_rises", 32'(rises), 1);
        chk("d10_busy", 32'(busyc), BCYC + 10 * CPC + HCYC);
        chk("d10_err", 32'(errc), 0);
        chk("d10_state", 32'(state), 0);
`ifdef ECHO_RESPONDER_COUNT_EN
        exp_count++;
`endif
        chk("d10_count", 32'(echo_count), 32'(exp_count));

        // Short trigger, one sample below minimum
        distance_cm = 9'd10;
        pulse(TMIN - 1);
        observe(0, 0, lat, width, rises, busyc, errc, errfirst);
        chk("short_err_cnt", 32'(errc), 1);
        chk("short_err_at", 32'(errfirst), 1);
        chk("short_width", 32'(width), 0);
        chk("short_busy", 32'(busyc), 0);
        chk("short_state", 32'(state), 0);

        // Distance above clamp
        distance_cm = 9'd500;
        pulse(TMIN);
        observe(0, 0, lat, width, rises, busyc, errc, errfirst);
        chk("clamp_width", 32'(width), MCM * CPC);
        chk("clamp_busy", 32'(busyc), BCYC + MCM * CPC + HCYC);
`ifdef ECHO_RESPONDER_COUNT_EN
        exp_count++;
`endif

        // Distance zero skips the echo entirely
        distance_cm = 9'd0;
        pulse(TMIN);
        observe(0, 0, lat, width, rises, busyc, errc, errfirst);
        chk("zero_width", 32'(width), 0);
        chk("zero_busy", 32'(busyc), BCYC + HCYC);
        chk("zero_count", 32'(echo_count), 32'(exp_count));
        chk("zero_state", 32'(state), 0);

        // Long retrigger during ECHO is ignored
        distance_cm = 9'd10;
        pulse(TMIN);
        observe(30, 2 * TMIN, lat, width, rises, busyc, errc, errfirst);
        chk("retrig_width", 32'(width), 10 * CPC);
        chk("retrig_rises", 32'(rises), 1);
        chk("retrig_err", 32'(errc), 0);
        chk("retrig_busy", 32'(busyc), BCYC + 10 * CPC + HCYC);
`ifdef ECHO_RESPONDER_COUNT_EN
        exp_count++;
`endif

        // Three distance-5 measurements
        for (int k = 0; k < 3; k++) begin
            distance_cm = 9'd5;
            pulse(TMIN);
            observe(0, 0, lat, width, rises, busyc, errc, errfirst);
            chk("d5_width", 32'(width), 5 * CPC);
`ifdef ECHO_RESPONDER_COUNT_EN
            exp_count++;
`endif
        end
        chk("d5_count", 32'(echo_count), 32'(exp_count));

        // Asynchronous reset in the middle of ECHO
        distance_cm = 9'd10;
        pulse(TMIN);
        repeat (BCYC + 10) tick();
        chk("pre_rst_echo", 32'(echo_tx), 1);
        chk("pre_rst_state", 32'(state), 3);
        #2;
        reset_n = 1'b0;
        trig_in = 1'b1;
        #1;
        chk("async_echo", 32'(echo_tx), 0);
        chk("async_state", 32'(state), 0);
        chk("async_count", 32'(echo_count), 0);
        exp_count = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        bad_states = 0;
        repeat (20) begin
            tick();
            if (state != 3'd0 || busy) bad_states++;
        end
        chk("held_trig_idle", 32'(bad_states), 0);
        trig_in = 1'b0;
        tick();
        pulse(TMIN);
        observe(0, 0, lat, width, rises, busyc, errc, errfirst);
        chk("post_rst_latency", 32'(lat), BCYC + 1);
        chk("post_rst_width", 32'(width), 10 * CPC);
`ifdef ECHO_RESPONDER_COUNT_EN
        exp_count++;
`endif
        chk("post_rst_count", 32'(echo_count), 32'(exp_count));
        chk("final_state", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
